// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: instruction reads and data reads/writes share one memory port.
// Round-robin on ties; each winning command is latched and runs to completion.
//
//   state   | meaning
//   IDLE    | no transaction; memory strobes low, next request picked at the edge
//   GRANT_I | instruction read owns the memory port
//   GRANT_D | data read/write owns the memory port
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_byte_enable,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic        last_d_q, last_d_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic        i_resp_q, i_resp_d;
  logic        d_resp_q, d_resp_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        d_req;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    last_d_d  = last_d_q;
    write_d   = write_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        armed_d = 1'b0;
        // On a tie the instruction port wins only if data was served last.
        if (i_read && (!d_req || last_d_q)) begin
          state_d = GRANT_I;
          write_d = 1'b0;
          addr_d  = i_address;
          be_d    = 2'b11;
          wdata_d = 16'h0000;
        end else if (d_req) begin
          state_d = GRANT_D;
          write_d = d_write;
          addr_d  = d_address;
          be_d    = d_byte_enable;
          wdata_d = d_wdata;
        end
      end
      GRANT_I, GRANT_D: begin
        // The first grant cycle only arms; a stale mem_resp cannot complete it.
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (mem_resp) begin
          state_d  = IDLE;
          armed_d  = 1'b0;
          last_d_d = (state_q == GRANT_D);
          if (state_q == GRANT_D) begin
            d_rdata_d = mem_rdata;
            d_resp_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_resp_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      last_d_q  <= 1'b1;
      write_q   <= 1'b0;
      addr_q    <= 16'h0000;
      be_q      <= 2'b00;
      wdata_q   <= 16'h0000;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      last_d_q  <= last_d_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_read        = (state_q != IDLE) && !write_q;
  assign mem_write       = (state_q != IDLE) && write_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign i_resp          = i_resp_q;
  assign d_resp          = d_resp_q;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-port transactions plus
// hand-written sequences for ties, mid-grant changes, resets and spurious responses.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Both responses must never be high together.
  always @(negedge clk) begin
    if (rst_n) chk("resp_exclusive", {31'd0, i_resp & d_resp}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    logic        exp_read;
    logic        exp_write;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [5];
  logic [15:0] exp_i_rd;
  logic [15:0] exp_d_rd;

  task automatic check_grant(input vec_t v);
    chk("mem_read", {31'd0, mem_read}, {31'd0, v.exp_read});
    chk("mem_write", {31'd0, mem_write}, {31'd0, v.exp_write});
    chk("mem_address", {16'd0, mem_address}, {16'd0, v.addr});
    chk("mem_byte_enable", {30'd0, mem_byte_enable}, {30'd0, v.exp_be});
    chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.exp_wdata});
    chk("no_early_resp", {30'd0, i_resp, d_resp}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_byte_enable = v.be;
      d_address = v.addr; d_wdata = v.wdata;
      i_address = 16'hDEAD;
    end else begin
      i_read = 1'b1; i_address = v.addr;
      d_address = 16'h5A5A; d_wdata = 16'h6B6B; d_byte_enable = 2'b10;
    end
    tick();
    for (int c = 0; c < v.lat; c++) begin
      check_grant(v);
      tick();
    end
    check_grant(v);
    mem_resp = 1'b1;
    mem_rdata = v.rdata;
    tick();
    mem_resp = 1'b0;
    mem_rdata = 16'h0000;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if (v.is_d) exp_d_rd = v.rdata;
    else exp_i_rd = v.rdata;
    chk("i_resp_pulse", {31'd0, i_resp}, {31'd0, ~v.is_d});
    chk("d_resp_pulse", {31'd0, d_resp}, {31'd0, v.is_d});
    chk("i_rdata", {16'd0, i_rdata}, {16'd0, exp_i_rd});
    chk("d_rdata", {16'd0, d_rdata}, {16'd0, exp_d_rd});
    chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("idle_addr_hold", {16'd0, mem_address}, {16'd0, v.addr});
    tick();
    chk("resp_one_cycle", {30'd0, i_resp, d_resp}, 32'd0);
    chk("rdata_hold", {i_rdata, d_rdata}, {exp_i_rd, exp_d_rd});
  endtask

  initial begin
    // is_d rd wr be addr wdata rdata lat | exp_read exp_write exp_be exp_wdata
    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b1, 1'b0, 2'b11, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'b01, 16'h0102, 16'h1234, 16'h00AA, 1, 1'b0, 1'b1, 2'b01, 16'h1234};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'h0041, 16'h0000, 16'h1357, 1, 1'b1, 1'b0, 2'b11, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2'b10, 16'hFFFE, 16'hA5A5, 16'h0F0F, 2, 1'b0, 1'b1, 2'b10, 16'hA5A5};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b11, 16'h0200, 16'h5555, 16'hCAFE, 4, 1'b1, 1'b0, 2'b11, 16'h5555};

    i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_byte_enable = 0;
    d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
    exp_i_rd = 16'h0000; exp_d_rd = 16'h0000;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_strobes", {28'd0, mem_read, mem_write, i_resp, d_resp}, 32'd0);
    chk("reset_addr_wdata", {mem_address, mem_wdata}, 32'd0);
    chk("reset_be", {30'd0, mem_byte_enable}, 32'd0);
    chk("reset_rdata", {i_rdata, d_rdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Tie after reset: I, D, I, D with both requests held.
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000; d_byte_enable = 2'b11;
    tick();
    for (int n = 0; n < 4; n++) begin
      chk("tie_grant_addr", {16'd0, mem_address}, (n % 2 == 1) ? 32'h2000 : 32'h1000);
      chk("tie_mem_read", {31'd0, mem_read}, 32'd1);
      tick();
      mem_resp = 1'b1; mem_rdata = 16'h0100 + 16'(n);
      tick();
      mem_resp = 1'b0;
      if (n == 3) begin i_read = 1'b0; d_read = 1'b0; end
      chk("tie_resp", {30'd0, i_resp, d_resp}, (n % 2 == 1) ? 32'd1 : 32'd2);
      chk("tie_idle_gap", {30'd0, mem_read, mem_write}, 32'd0);
      tick();
    end
    exp_i_rd = 16'h0102; exp_d_rd = 16'h0103;
    chk("tie_rdata", {i_rdata, d_rdata}, {exp_i_rd, exp_d_rd});

    foreach (vecs[k]) run_vec(vecs[k]);

    // Mid-grant address change and stale response in the first grant cycle.
    d_read = 1'b1; d_address = 16'h0010; d_byte_enable = 2'b11;
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h9999;
    d_address = 16'h0020;
    chk("mid_addr_c1", {16'd0, mem_address}, 32'h0010);
    tick();
    mem_resp = 1'b0;
    chk("first_cycle_resp_ignored", {31'd0, d_resp}, 32'd0);
    chk("still_granted", {31'd0, mem_read}, 32'd1);
    chk("mid_addr_c2", {16'd0, mem_address}, 32'h0010);
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h7777;
    d_read = 1'b0;
    chk("mid_addr_c3", {16'd0, mem_address}, 32'h0010);
    tick();
    mem_resp = 1'b0;
    chk("mid_d_resp", {31'd0, d_resp}, 32'd1);
    chk("mid_d_rdata", {16'd0, d_rdata}, 32'h7777);
    exp_d_rd = 16'h7777;
    tick();

    // Spurious response while idle.
    mem_resp = 1'b1; mem_rdata = 16'h4444;
    tick();
    tick();
    mem_resp = 1'b0;
    chk("spurious_resp", {30'd0, i_resp, d_resp}, 32'd0);
    chk("spurious_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("spurious_rdata", {i_rdata, d_rdata}, {exp_i_rd, exp_d_rd});

    // Reset in the middle of a data write.
    d_write = 1'b1; d_address = 16'h0300; d_wdata = 16'h8888; d_byte_enable = 2'b10;
    tick();
    chk("pre_reset_write", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    d_write = 1'b0;
    #1;
    chk("async_reset_strobes", {28'd0, mem_read, mem_write, i_resp, d_resp}, 32'd0);
    chk("async_reset_addr_wdata", {mem_address, mem_wdata}, 32'd0);
    chk("async_reset_be", {30'd0, mem_byte_enable}, 32'd0);
    chk("async_reset_rdata", {i_rdata, d_rdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_resp = 1'b0;
    chk("late_resp_no_d_resp", {30'd0, i_resp, d_resp}, 32'd0);
    chk("late_resp_idle", {30'd0, mem_read, mem_write}, 32'd0);
    tick();
    chk("late_resp_idle2", {30'd0, mem_read, mem_write, i_resp, d_resp}, 32'd0);
    chk("late_resp_rdata", {i_rdata, d_rdata}, 32'd0);

    // Last-granted reset to D, so I wins the next tie.
    i_read = 1'b1; i_address = 16'h3000;
    d_read = 1'b1; d_address = 16'h4000;
    tick();
    chk("post_reset_tie", {16'd0, mem_address}, 32'h3000);
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h2468;
    tick();
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    chk("post_reset_i_resp", {30'd0, i_resp, d_resp}, 32'd2);
    chk("post_reset_i_rdata", {16'd0, i_rdata}, 32'h2468);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
